alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU: ARM data-processing op set over WIDTH bits, plus an iterative multiplier.
- Owns the architectural NZCV flag register instead of taking CPSR bits combinationally.
- Sits between register-file read and writeback.
- Uses a valid/ready input handshake and a one-cycle result strobe, so the pipeline stalls only while MUL iterates.

Parameters:
- WIDTH, 32: operand/result width; must be at least 8.
- MUL_STEP, 1: multiplier bits retired per cycle; must divide WIDTH; MUL latency N = WIDTH/MUL_STEP.
- MUL_EN, 1: 0 removes the multiplier; MUL requests then behave as MOV of 0 with flags unchanged.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  block can accept; equals state==IDLE
- op  in  4  ARM DP opcode: AND0 EOR1 SUB2 RSB3 ADD4 ADC5 SBC6 RSC7 TST8 TEQ9 CMP10 CMN11 ORR12 MOV13 BIC14 MVN15
- mul  in  1  1 = multiply a*b; op is ignored
- set_flags  in  1  S bit; ignored for TST/TEQ/CMP/CMN, which always set flags
- a  in  WIDTH  operand Rn
- b  in  WIDTH  operand (shifter output)
- shift_carry  in  1  shifter carry-out, used as C for logical ops
- flush  in  1  abort in-flight MUL
- out_valid  out  1  result strobe, high for one cycle
- out_result  out  WIDTH  result, held until the next strobe
- out_wr  out  1  result should be written back; 0 for test ops
- flags  out  4  {N,Z,C,V}, registered

Behaviour:
- Reset, asynchronous: state=IDLE, out_valid=0, out_result=0, out_wr=0, flags=4'b0000, multiplier counter=0. Applies mid-MUL: the operation is lost and no strobe is produced.
- Accept: in_valid & in_ready at a rising edge. Inputs are sampled only at accept. in_valid while busy is ignored; the requester holds it.
- Single-cycle ops: accepted at edge k → out_valid=1 after edge k. out_result, out_wr and flags update at that same edge. in_ready stays 1, so back-to-back ops issue every cycle.
- Arithmetic is performed at WIDTH+1 bits.
  - ADD: a+b.
  - ADC: a+b+C.
  - SUB/CMP: a+~b+1.
  - SBC: a+~b+C.
  - RSB: b+~a+1.
  - RSC: b+~a+C.
  - CMN: a+b.
- Arithmetic flags: C = bit WIDTH of the sum (ARM no-borrow convention for subtracts). V = operands' effective signs equal and result sign differs.
- Logical ops (AND, EOR, ORR, MOV, BIC=a&~b, MVN=~b, TST, TEQ): C=shift_carry, V unchanged.
- N = result[WIDTH-1]; Z = (result==0) over all ops.
- Flags are written only when set_flags=1 or the op is TST/TEQ/CMP/CMN; otherwise flags hold.
- Test ops: out_wr=0; out_result carries the computed value for debug.
- ADC/SBC/RSC use the flags value current at accept. Result-to-flags forwarding is therefore automatic for back-to-back issue.
- MUL, state machine IDLE→MUL→IDLE:
  - On accept, latch a and b, clear the accumulator, load counter=N; in_ready=0.
  - Each edge in MUL adds MUL_STEP partial products (shift-add) and decrements the counter.
  - On the edge where counter==1: register the low WIDTH bits of the product, out_valid=1, out_wr=1, return to IDLE.
  - Latency: accept at edge k → out_valid after edge k+N. For WIDTH=32, MUL_STEP=1 that is 32.
  - MUL flags with set_flags: N, Z updated; C, V unchanged.
- out_valid deasserts the cycle after the strobe unless a new single-cycle op was accepted at that same edge.
- flush:
  - Sampled synchronously; it is not a reset.
  - In MUL: return to IDLE with no strobe and no flag change.
  - In IDLE: blocks an accept that same edge.
  - flush has priority over MUL completion on the same edge.
- Width rule: all internal sums are WIDTH+1 bits and the product accumulator is WIDTH bits (truncating). No X is ever driven on any output.

Decomposition:
- Package alu_pkg:
  - op_e enum (16 opcodes above).
  - Flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - state_e {IDLE, MUL}.
  - is_test(op) and is_logical(op) functions.
- Sub-module alu_mul_iter (WIDTH, MUL_STEP):
  - Inputs: start, flush, a, b.
  - Outputs: busy, done (one-cycle pulse), product.
  - alu_seq owns the handshake, flags and result register.

Test Plan:
- ADD, S=1, a=0x7FFFFFFF, b=1 → after one edge out_valid=1, out_result=0x80000000, out_wr=1, flags=1001.
- CMP a=5, b=5, S=0 → out_wr=0, flags=0110. Then ADD S=0 of 1+1 → result 2, flags stay 0110.
- SUB S=1 3−5 → 0xFFFFFFFE, flags=1000. Next-cycle ADC S=0 of 1+1 → 2, since C=0. Back-to-back: SUB S=1 5−3 (C=1) then ADC 1+1 → 3.
- MUL a=6, b=7, S=1, WIDTH=32 → in_ready=0 for 32 cycles, in_valid held with ADD ignored, out_valid after edge k+32 with result 42, flags N=0 Z=0, C/V unchanged. The ADD is then accepted next edge.
- MUL a=0xFFFFFFFF, b=2 → 0xFFFFFFFE, N=1. With MUL_STEP=4: latency 8.
- Reset asserted asynchronously mid-MUL (cycle 10) → outputs 0, flags 0000, in_ready=1 immediately, no strobe. flush at cycle 10 instead → no strobe, flags unchanged, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag index and state definitions shared by the ALU block
package alu_pkg;

   typedef enum logic [3:0] {
      OP_AND = 4'd0,  OP_EOR = 4'd1,  OP_SUB = 4'd2,  OP_RSB = 4'd3,
      OP_ADD = 4'd4,  OP_ADC = 4'd5,  OP_SBC = 4'd6,  OP_RSC = 4'd7,
      OP_TST = 4'd8,  OP_TEQ = 4'd9,  OP_CMP = 4'd10, OP_CMN = 4'd11,
      OP_ORR = 4'd12, OP_MOV = 4'd13, OP_BIC = 4'd14, OP_MVN = 4'd15
   } op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_e;

   function automatic logic is_test(op_e op);
      return op inside {OP_TST, OP_TEQ, OP_CMP, OP_CMN};
   endfunction

   function automatic logic is_logical(op_e op);
      return op inside {OP_AND, OP_EOR, OP_TST, OP_TEQ, OP_ORR, OP_MOV, OP_BIC, OP_MVN};
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add multiplier retiring MUL_STEP bits per cycle
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int N  = WIDTH / MUL_STEP;
   localparam int CW = $clog2(N + 1);

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;

   always_comb begin
      acc_next = acc;
      for (int j = 0; j < MUL_STEP; j++) begin
         if (b_sh[j]) acc_next = acc_next + (a_sh << j);
      end
   end

   // done and product are combinational so the owner registers the result on the final edge
   assign busy    = (cnt != '0);
   assign done    = (cnt == CW'(1)) && !flush;
   assign product = acc_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         acc  <= '0;
         a_sh <= '0;
         b_sh <= '0;
      end else if (flush) begin
         cnt <= '0;
      end else if (start) begin
         a_sh <= a;
         b_sh <= b;
         acc  <= '0;
         cnt  <= CW'(N);
      end else if (cnt != '0) begin
         acc  <= acc_next;
         a_sh <= a_sh << MUL_STEP;
         b_sh <= b_sh >> MUL_STEP;
         cnt  <= cnt - CW'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered ARM data-processing ALU with NZCV register and iterative MUL
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_STEP = 1,
   parameter int MUL_EN   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             mul,
   input  logic             set_flags,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             shift_carry,
   input  logic             flush,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_result,
   output logic             out_wr,
   output logic [3:0]       flags
);

   state_e           state;
   op_e              opc;
   logic             accept;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic             mul_set_flags;
   logic [WIDTH-1:0] x, y, res;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [3:0]       nzcv;

   assign opc       = op_e'(op);
   assign in_ready  = (state == IDLE);
   assign accept    = in_valid && in_ready && !flush;
   assign mul_start = accept && mul;

   // Subtracts fold into one adder by inverting an operand and choosing the carry-in
   always_comb begin
      x   = a;
      y   = b;
      cin = 1'b0;
      unique case (opc)
         OP_ADC:         cin = flags[FLAG_C];
         OP_SUB, OP_CMP: begin y = ~b; cin = 1'b1; end
         OP_SBC:         begin y = ~b; cin = flags[FLAG_C]; end
         OP_RSB:         begin x = b; y = ~a; cin = 1'b1; end
         OP_RSC:         begin x = b; y = ~a; cin = flags[FLAG_C]; end
         default:        ;
      endcase
      sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};

      unique case (opc)
         OP_AND, OP_TST: res = a & b;
         OP_EOR, OP_TEQ: res = a ^ b;
         OP_ORR:         res = a | b;
         OP_MOV:         res = b;
         OP_BIC:         res = a & ~b;
         OP_MVN:         res = ~b;
         default:        res = sum[WIDTH-1:0];
      endcase

      nzcv         = flags;
      nzcv[FLAG_N] = res[WIDTH-1];
      nzcv[FLAG_Z] = (res == '0);
      if (is_logical(opc)) begin
         nzcv[FLAG_C] = shift_carry;
      end else begin
         nzcv[FLAG_C] = sum[WIDTH];
         nzcv[FLAG_V] = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
      end
   end

   if (MUL_EN != 0) begin : g_mul
      alu_mul_iter #(.WIDTH(WIDTH), .MUL_STEP(MUL_STEP)) u_mul (
         .clk     (clk),
         .reset   (reset),
         .start   (mul_start),
         .flush   (flush),
         .a       (a),
         .b       (b),
         .busy    (mul_busy),
         .done    (mul_done),
         .product (mul_product)
      );
   end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         out_valid     <= 1'b0;
         out_result    <= '0;
         out_wr        <= 1'b0;
         flags         <= 4'b0000;
         mul_set_flags <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         unique case (state)
            IDLE: begin
               if (accept) begin
                  if (mul && MUL_EN != 0) begin
                     state         <= MUL;
                     mul_set_flags <= set_flags;
                  end else if (mul) begin
                     out_valid  <= 1'b1;
                     out_result <= '0;
                     out_wr     <= 1'b1;
                  end else begin
                     out_valid  <= 1'b1;
                     out_result <= res;
                     out_wr     <= !is_test(opc);
                     if (set_flags || is_test(opc)) flags <= nzcv;
                  end
               end
            end
            MUL: begin
               if (flush) begin
                  state <= IDLE;
               end else if (mul_done) begin
                  state      <= IDLE;
                  out_valid  <= 1'b1;
                  out_result <= mul_product;
                  out_wr     <= 1'b1;
                  if (mul_set_flags) begin
                     flags[FLAG_N] <= mul_product[WIDTH-1];
                     flags[FLAG_Z] <= (mul_product == '0);
                  end
               end else if (!mul_busy) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_valid4 = 1'b0;
   logic [3:0]  op = 4'd0;
   logic        mul = 1'b0;
   logic        set_flags = 1'b0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        shift_carry = 1'b0;
   logic        flush = 1'b0;

   logic        in_ready, out_valid, out_wr;
   logic [31:0] out_result;
   logic [3:0]  flags;
   logic        in_ready4, out_valid4, out_wr4;
   logic [31:0] out_result4;
   logic [3:0]  flags4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32), .MUL_STEP(1), .MUL_EN(1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .mul(mul), .set_flags(set_flags), .a(a), .b(b),
      .shift_carry(shift_carry), .flush(flush), .out_valid(out_valid),
      .out_result(out_result), .out_wr(out_wr), .flags(flags)
   );

   alu_seq #(.WIDTH(32), .MUL_STEP(4), .MUL_EN(1)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
      .op(op), .mul(mul), .set_flags(set_flags), .a(a), .b(b),
      .shift_carry(shift_carry), .flush(flush), .out_valid(out_valid4),
      .out_result(out_result4), .out_wr(out_wr4), .flags(flags4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic m, input logic s,
                        input logic [31:0] va, input logic [31:0] vb);
      in_valid  = 1'b1;
      op        = o;
      mul       = m;
      set_flags = s;
      a         = va;
      b         = vb;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL reset_out_result got=%h exp=0", out_result); end
      checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b exp=0000", flags); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_add_overflow();
      drive(4'd4, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1);
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_valid got=%b exp=1", out_valid); end
      checks++; if (out_result !== 32'h8000_0000) begin failures++; $display("FAIL add_result got=%h exp=80000000", out_result); end
      checks++; if (out_wr !== 1'b1) begin failures++; $display("FAIL add_wr got=%b exp=1", out_wr); end
      checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL add_flags got=%b exp=1001", flags); end
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_valid_drop got=%b exp=0", out_valid); end
   endtask

   task automatic test_cmp();
      drive(4'd10, 1'b0, 1'b0, 32'd5, 32'd5);
      tick();
      checks++; if (out_wr !== 1'b0) begin failures++; $display("FAIL cmp_wr got=%b exp=0", out_wr); end
      checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL cmp_flags got=%b exp=0110", flags); end
      checks++; if (out_result !== 32'd0) begin failures++; $display("FAIL cmp_result got=%h exp=0", out_result); end
      drive(4'd4, 1'b0, 1'b0, 32'd1, 32'd1);
      tick();
      in_valid = 1'b0;
      checks++; if (out_result !== 32'd2) begin failures++; $display("FAIL add_nos_result got=%h exp=2", out_result); end
      checks++; if (flags !== 4'b0110) begin failures++; $display("FAIL add_nos_flags got=%b exp=0110", flags); end
      checks++; if (out_wr !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL add_nos_wr got=%b%b exp=11", out_wr, out_valid); end
   endtask

   task automatic test_back_to_back();
      drive(4'd2, 1'b0, 1'b1, 32'd3, 32'd5);
      tick();
      checks++; if (out_result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_neg_result got=%h exp=fffffffe", out_result); end
      checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL sub_neg_flags got=%b exp=1000", flags); end
      drive(4'd5, 1'b0, 1'b0, 32'd1, 32'd1);
      tick();
      checks++; if (out_result !== 32'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL adc_c0 got=%h/%b exp=2/1", out_result, out_valid); end
      drive(4'd2, 1'b0, 1'b1, 32'd5, 32'd3);
      tick();
      checks++; if (out_result !== 32'd2) begin failures++; $display("FAIL sub_pos_result got=%h exp=2", out_result); end
      checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL sub_pos_flags got=%b exp=0010", flags); end
      drive(4'd5, 1'b0, 1'b0, 32'd1, 32'd1);
      tick();
      in_valid = 1'b0;
      checks++; if (out_result !== 32'd3) begin failures++; $display("FAIL adc_c1 got=%h exp=3", out_result); end
      tick();
   endtask

   task automatic test_mul();
      int strobe_at;
      int busy_bad;
      strobe_at = -1;
      busy_bad  = 0;
      drive(4'd0, 1'b1, 1'b1, 32'd6, 32'd7);
      tick();
      drive(4'd4, 1'b0, 1'b0, 32'd10, 32'd20);
      for (int i = 1; i <= 40 && strobe_at < 0; i++) begin
         tick();
         if (out_valid === 1'b1) strobe_at = i;
         else if (in_ready !== 1'b0) busy_bad++;
      end
      checks++; if (strobe_at != 32) begin failures++; $display("FAIL mul_latency got=%0d exp=32", strobe_at); end
      checks++; if (busy_bad != 0) begin failures++; $display("FAIL mul_in_ready_busy got=%0d exp=0", busy_bad); end
      checks++; if (out_result !== 32'd42 || out_wr !== 1'b1) begin failures++; $display("FAIL mul_result got=%h/%b exp=2a/1", out_result, out_wr); end
      checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL mul_flags got=%b exp=0010", flags); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_result !== 32'd30) begin failures++; $display("FAIL held_add got=%h/%b exp=1e/1", out_result, out_valid); end

      drive(4'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2);
      tick();
      in_valid = 1'b0;
      for (int i = 1; i <= 32; i++) tick();
      checks++; if (out_valid !== 1'b1 || out_result !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_neg got=%h/%b exp=fffffffe/1", out_result, out_valid); end
      checks++; if (flags !== 4'b1010) begin failures++; $display("FAIL mul_neg_flags got=%b exp=1010", flags); end
   endtask

   task automatic test_mul_step4();
      int strobe_at;
      strobe_at = -1;
      in_valid  = 1'b0;
      in_valid4 = 1'b1;
      op = 4'd0; mul = 1'b1; set_flags = 1'b1; a = 32'hFFFF_FFFF; b = 32'd2;
      tick();
      in_valid4 = 1'b0;
      for (int i = 1; i <= 20 && strobe_at < 0; i++) begin
         tick();
         if (out_valid4 === 1'b1) strobe_at = i;
      end
      checks++; if (strobe_at != 8) begin failures++; $display("FAIL mul4_latency got=%0d exp=8", strobe_at); end
      checks++; if (out_result4 !== 32'hFFFF_FFFE || flags4 !== 4'b1000) begin failures++; $display("FAIL mul4_result got=%h/%b exp=fffffffe/1000", out_result4, flags4); end
   endtask

   task automatic test_reset_mid_mul();
      int strobes;
      strobes = 0;
      drive(4'd0, 1'b1, 1'b1, 32'd6, 32'd7);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      reset = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", in_ready); end
      checks++; if (flags !== 4'b0000 || out_result !== 32'd0 || out_wr !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_outputs got=%b/%h/%b/%b exp=0000/0/0/0", flags, out_result, out_wr, out_valid); end
      tick();
      reset = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid === 1'b1) strobes++;
      end
      checks++; if (strobes != 0) begin failures++; $display("FAIL rst_mid_strobe got=%0d exp=0", strobes); end
   endtask

   task automatic test_flush();
      int strobes;
      strobes = 0;
      drive(4'd4, 1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1);
      tick();
      drive(4'd0, 1'b1, 1'b1, 32'd3, 32'd3);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_mul got=%b/%b exp=1/0", in_ready, out_valid); end
      checks++; if (flags !== 4'b1001) begin failures++; $display("FAIL flush_flags got=%b exp=1001", flags); end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (out_valid === 1'b1) strobes++;
      end
      checks++; if (strobes != 0) begin failures++; $display("FAIL flush_strobe got=%0d exp=0", strobes); end
      drive(4'd4, 1'b0, 1'b1, 32'd2, 32'd2);
      flush = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b0 || out_result !== 32'h8000_0000) begin failures++; $display("FAIL flush_idle got=%h/%b exp=80000000/0", out_result, out_valid); end
   endtask

   initial begin
      test_reset();
      test_add_overflow();
      test_cmp();
      test_back_to_back();
      test_mul();
      test_mul_step4();
      test_reset_mid_mul();
      test_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
